// File: rtl/prog_timeout_counter_if.sv
// Control and status bundle for prog_timeout_counter.
// The master side drives the controls; the counter is the slave.
interface prog_timeout_counter_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] limit_in;
    logic             mode;
    logic             clear_flag;
    logic [WIDTH-1:0] count;
    logic             reached;
    logic             reached_pulse;
    logic             busy;

    modport master (
        output enable, load, limit_in, mode, clear_flag,
        input  count, reached, reached_pulse, busy
    );

    modport slave (
        input  enable, load, limit_in, mode, clear_flag,
        output count, reached, reached_pulse, busy
    );
endinterface

// File: rtl/prog_timeout_counter.sv
// Programmable timeout counter: a prescaled step counter that fires at a loadable limit,
// in one-shot or periodic mode, with a sticky flag and a one-cycle pulse.
module prog_timeout_counter #(
    parameter int WIDTH         = 16,
    parameter int DEFAULT_LIMIT = 10,
    parameter int PRESCALE      = 1
) (
    input  logic                   tick,
    input  logic                   reset,
    prog_timeout_counter_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] LIM_RST  = WIDTH'(DEFAULT_LIMIT);

    typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] limit_q, limit_n;
    logic [PW-1:0]    pre_q, pre_n;
    logic             reached_q, reached_n;
    logic             pulse_q, pulse_n;
    logic [WIDTH:0]   next_cnt;

    // One extra bit on the increment so limit = all-ones never wraps
    assign next_cnt = {1'b0, count_q} + (WIDTH+1)'(1);

    always_ff @(posedge tick) begin
        if (reset) begin
            state     <= RUN;
            count_q   <= '0;
            limit_q   <= LIM_RST;
            pre_q     <= '0;
            reached_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state     <= state_n;
            count_q   <= count_n;
            limit_q   <= limit_n;
            pre_q     <= pre_n;
            reached_q <= reached_n;
            pulse_q   <= pulse_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count_q;
        limit_n   = limit_q;
        pre_n     = pre_q;
        reached_n = reached_q & ~bus.clear_flag;
        pulse_n   = 1'b0;
        if (bus.load) begin
            limit_n   = bus.limit_in;
            count_n   = '0;
            pre_n     = '0;
            reached_n = 1'b0;
            state_n   = RUN;
        end else if (state == RUN && bus.enable) begin
            if (pre_q == PRE_LAST) begin
                pre_n = '0;
                if (next_cnt >= {1'b0, limit_q}) begin
                    // Fire: setting the flag overrides a same-edge clear
                    reached_n = 1'b1;
                    pulse_n   = 1'b1;
                    if (bus.mode) begin
                        count_n = '0;
                    end else begin
                        count_n = limit_q;
                        state_n = DONE;
                    end
                end else begin
                    count_n = next_cnt[WIDTH-1:0];
                end
            end else begin
                pre_n = pre_q + PW'(1);
            end
        end
    end

    assign bus.count         = count_q;
    assign bus.reached       = reached_q;
    assign bus.reached_pulse = pulse_q;
    assign bus.busy          = (state == RUN);
endmodule

// File: tb/tb_prog_timeout_counter.sv
// Bench for prog_timeout_counter: directed scenarios plus a randomized run against
// a tick-count reference model, on a 16-bit/PRESCALE=1 and a 4-bit/PRESCALE=4 instance.
module tb_prog_timeout_counter;
    logic        tick = 1'b0;
    logic        rst, en, ld, md, clr;
    logic [15:0] lim;
    int          n_chk = 0;
    int          n_err = 0;

    // Reference model state per instance: enabled ticks since period start
    int m_t[2], m_L[2];
    bit m_done[2], m_reached[2], m_pulse[2];
    int P[2]    = '{1, 4};
    int MASK[2] = '{16'hFFFF, 4'hF};

    always #5 tick = ~tick;

    prog_timeout_counter_if #(.WIDTH(16)) if0 ();
    prog_timeout_counter_if #(.WIDTH(4))  if1 ();

    assign if0.enable = en;  assign if1.enable = en;
    assign if0.load = ld;    assign if1.load = ld;
    assign if0.mode = md;    assign if1.mode = md;
    assign if0.clear_flag = clr;
    assign if1.clear_flag = clr;
    assign if0.limit_in = lim;
    assign if1.limit_in = lim[3:0];

    prog_timeout_counter #(.WIDTH(16), .DEFAULT_LIMIT(10), .PRESCALE(1)) dut0 (
        .tick(tick), .reset(rst), .bus(if0));
    prog_timeout_counter #(.WIDTH(4), .DEFAULT_LIMIT(10), .PRESCALE(4)) dut1 (
        .tick(tick), .reset(rst), .bus(if1));

    task automatic edge_();
        @(posedge tick);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; ld = 0; md = 0; clr = 0; lim = 0;
        edge_();
        rst = 0;
    endtask

    task automatic model_edge(int k);
        int lim1;
        if (rst) begin
            m_L[k] = 10; m_t[k] = 0; m_done[k] = 0; m_reached[k] = 0; m_pulse[k] = 0;
            return;
        end
        m_pulse[k] = 0;
        if (ld) begin
            m_L[k] = int'(lim) & MASK[k]; m_t[k] = 0; m_done[k] = 0; m_reached[k] = 0;
        end else begin
            if (clr) m_reached[k] = 0;
            if (!m_done[k] && en) begin
                m_t[k]++;
                lim1 = (m_L[k] == 0) ? 1 : m_L[k];
                if (m_t[k] == lim1 * P[k]) begin
                    m_reached[k] = 1; m_pulse[k] = 1; m_t[k] = 0;
                    if (!md) m_done[k] = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (if0.count !== 16'd0) begin n_err++; $display("FAIL reset_count0: got %0d want 0", if0.count); end
        n_chk++; if (if0.reached !== 1'b0) begin n_err++; $display("FAIL reset_reached0: got %b want 0", if0.reached); end
        n_chk++; if (if0.reached_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse0: got %b want 0", if0.reached_pulse); end
        n_chk++; if (if0.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy0: got %b want 1", if0.busy); end
        n_chk++; if (if1.count !== 4'd0) begin n_err++; $display("FAIL reset_count1: got %0d want 0", if1.count); end
        n_chk++; if (if1.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy1: got %b want 1", if1.busy); end
    endtask

    task automatic test_default_oneshot();
        do_reset();
        en = 1; md = 0;
        for (int k = 1; k <= 12; k++) begin
            edge_();
            n_chk++; if (if0.count !== 16'(k >= 10 ? 10 : k)) begin n_err++;
                $display("FAIL default_count edge %0d: got %0d want %0d", k, if0.count, (k >= 10 ? 10 : k)); end
            n_chk++; if (if0.reached_pulse !== (k == 10)) begin n_err++;
                $display("FAIL default_pulse edge %0d: got %b want %b", k, if0.reached_pulse, (k == 10)); end
            n_chk++; if (if0.reached !== (k >= 10)) begin n_err++;
                $display("FAIL default_reached edge %0d: got %b want %b", k, if0.reached, (k >= 10)); end
            n_chk++; if (if0.busy !== (k < 10)) begin n_err++;
                $display("FAIL default_busy edge %0d: got %b want %b", k, if0.busy, (k < 10)); end
        end
    endtask

    task automatic test_periodic_prescaled();
        do_reset();
        lim = 3; md = 1; en = 1; ld = 1;
        edge_();
        ld = 0;
        n_chk++; if (if1.count !== 4'd0) begin n_err++; $display("FAIL periodic_load_count: got %0d want 0", if1.count); end
        for (int k = 1; k <= 26; k++) begin
            edge_();
            n_chk++; if (if1.count !== 4'((k % 12) / 4)) begin n_err++;
                $display("FAIL periodic_count edge %0d: got %0d want %0d", k, if1.count, (k % 12) / 4); end
            n_chk++; if (if1.reached_pulse !== (k % 12 == 0)) begin n_err++;
                $display("FAIL periodic_pulse edge %0d: got %b want %b", k, if1.reached_pulse, (k % 12 == 0)); end
            n_chk++; if (if1.reached !== (k >= 12)) begin n_err++;
                $display("FAIL periodic_reached edge %0d: got %b want %b", k, if1.reached, (k >= 12)); end
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        en = 1; md = 0;
        repeat (4) edge_();
        en = 0;
        for (int k = 5; k <= 9; k++) begin
            edge_();
            n_chk++; if (if0.count !== 16'd4) begin n_err++; $display("FAIL gate_hold edge %0d: got %0d want 4", k, if0.count); end
        end
        en = 1;
        for (int k = 10; k <= 16; k++) begin
            edge_();
            n_chk++; if (if0.reached_pulse !== (k == 15)) begin n_err++;
                $display("FAIL gate_pulse edge %0d: got %b want %b", k, if0.reached_pulse, (k == 15)); end
        end
        n_chk++; if (if0.count !== 16'd10) begin n_err++; $display("FAIL gate_final_count: got %0d want 10", if0.count); end
    endtask

    task automatic test_load_limit0();
        do_reset();
        en = 1; md = 0;
        repeat (6) edge_();
        n_chk++; if (if0.count !== 16'd6) begin n_err++; $display("FAIL l0_pre_count: got %0d want 6", if0.count); end
        ld = 1; lim = 0;
        edge_();
        ld = 0;
        n_chk++; if (if0.count !== 16'd0 || if0.reached !== 1'b0 || if0.busy !== 1'b1) begin n_err++;
            $display("FAIL l0_after_load: got count=%0d reached=%b busy=%b want 0 0 1", if0.count, if0.reached, if0.busy); end
        edge_();
        n_chk++; if (if0.reached_pulse !== 1'b1 || if0.reached !== 1'b1 || if0.count !== 16'd0 || if0.busy !== 1'b0) begin n_err++;
            $display("FAIL l0_fire: got pulse=%b reached=%b count=%0d busy=%b want 1 1 0 0",
                     if0.reached_pulse, if0.reached, if0.count, if0.busy); end
        edge_();
        n_chk++; if (if0.reached_pulse !== 1'b0 || if0.count !== 16'd0) begin n_err++;
            $display("FAIL l0_hold: got pulse=%b count=%0d want 0 0", if0.reached_pulse, if0.count); end
    endtask

    task automatic test_clear_vs_fire();
        do_reset();
        en = 1; md = 0;
        repeat (9) edge_();
        clr = 1;
        edge_();
        n_chk++; if (if0.reached !== 1'b1 || if0.reached_pulse !== 1'b1) begin n_err++;
            $display("FAIL clr_fire_same_edge: got reached=%b pulse=%b want 1 1", if0.reached, if0.reached_pulse); end
        edge_();
        clr = 0;
        n_chk++; if (if0.reached !== 1'b0 || if0.count !== 16'd10) begin n_err++;
            $display("FAIL clr_after: got reached=%b count=%0d want 0 10", if0.reached, if0.count); end
    endtask

    task automatic test_max_limit_and_reset();
        do_reset();
        ld = 1; lim = 15; md = 0; en = 1;
        edge_();
        ld = 0;
        for (int k = 1; k <= 64; k++) begin
            edge_();
            n_chk++; if (if1.count !== 4'(k >= 60 ? 15 : k / 4)) begin n_err++;
                $display("FAIL max_count edge %0d: got %0d want %0d", k, if1.count, (k >= 60 ? 15 : k / 4)); end
            n_chk++; if (if1.reached_pulse !== (k == 60)) begin n_err++;
                $display("FAIL max_pulse edge %0d: got %b want %b", k, if1.reached_pulse, (k == 60)); end
        end
        // Periodic run so the flag is set when reset lands at count 7
        ld = 1; lim = 8; md = 1;
        edge_();
        ld = 0;
        repeat (32 + 28) edge_();
        n_chk++; if (if1.count !== 4'd7 || if1.reached !== 1'b1) begin n_err++;
            $display("FAIL rst_pre: got count=%0d reached=%b want 7 1", if1.count, if1.reached); end
        rst = 1;
        edge_();
        rst = 0;
        n_chk++; if (if1.count !== 4'd0 || if1.reached !== 1'b0 || if1.reached_pulse !== 1'b0 || if1.busy !== 1'b1) begin n_err++;
            $display("FAIL rst_mid: got count=%0d reached=%b pulse=%b busy=%b want 0 0 0 1",
                     if1.count, if1.reached, if1.reached_pulse, if1.busy); end
    endtask

    task automatic test_random();
        int ec;
        rst = 1; en = 0; ld = 0; md = 0; clr = 0; lim = 0;
        @(posedge tick);
        model_edge(0); model_edge(1);
        #1;
        rst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 150 == 0);
            ld  = ($urandom % 25 == 0);
            lim = ($urandom % 5 == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
            en  = ($urandom % 4 != 0);
            md  = $urandom % 2;
            clr = ($urandom % 10 == 0);
            @(posedge tick);
            model_edge(0); model_edge(1);
            #1;
            ec = m_done[0] ? m_L[0] : m_t[0] / P[0];
            n_chk++; if (if0.count !== 16'(ec) || if0.reached !== m_reached[0] ||
                         if0.reached_pulse !== m_pulse[0] || if0.busy !== !m_done[0]) begin n_err++;
                $display("FAIL rand0 cyc %0d: got c=%0d r=%b p=%b b=%b want c=%0d r=%b p=%b b=%b", i,
                         if0.count, if0.reached, if0.reached_pulse, if0.busy, ec, m_reached[0], m_pulse[0], !m_done[0]); end
            ec = m_done[1] ? m_L[1] : m_t[1] / P[1];
            n_chk++; if (if1.count !== 4'(ec) || if1.reached !== m_reached[1] ||
                         if1.reached_pulse !== m_pulse[1] || if1.busy !== !m_done[1]) begin n_err++;
                $display("FAIL rand1 cyc %0d: got c=%0d r=%b p=%b b=%b want c=%0d r=%b p=%b b=%b", i,
                         if1.count, if1.reached, if1.reached_pulse, if1.busy, ec, m_reached[1], m_pulse[1], !m_done[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_default_oneshot();
        test_periodic_prescaled();
        test_enable_gating();
        test_load_limit0();
        test_clear_vs_fire();
        test_max_limit_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/prog_timeout_counter.md
Name: prog_timeout_counter

Overview:
Parametrised programmable timeout counter, next generation of the fixed 10-count timeout block. Counts enabled clock steps through an optional prescaler up to a runtime-loadable limit, then raises a sticky `reached` flag and a one-cycle `reached_pulse`. Supports one-shot and periodic modes, freeze via enable, and explicit flag clear. Sits beside control FSMs as a generic delay/timeout/heartbeat source.

Parameters:
WIDTH, 16, bit width of count and limit
DEFAULT_LIMIT, 10, limit value after reset; must fit in WIDTH bits
PRESCALE, 1, enabled ticks per count step; must be >=1; prescaler register sized to hold PRESCALE-1

Ports:
tick  input  1  clock; all logic on rising edge
reset  input  1  synchronous reset, active-high
enable  input  1  1 = prescaler/count advance; 0 = freeze
load  input  1  strobe: latch limit_in, restart
limit_in  input  WIDTH  new limit, sampled when load=1
mode  input  1  0 = one-shot, 1 = periodic
clear_flag  input  1  clears sticky reached
count  output  WIDTH  current count value
reached  output  1  sticky terminal flag
reached_pulse  output  1  high exactly one cycle per fire
busy  output  1  1 while state==RUN

Behaviour:
- Single clock `tick`; reset synchronous, active-high; no other async paths.
- States: RUN, DONE. busy = (state==RUN).
- Reset (highest priority): state=RUN, count=0, prescaler=0, limit=DEFAULT_LIMIT, reached=0, reached_pulse=0. Counting starts on first edge after reset deasserts if enable=1.
- load (priority below reset, above all else): limit<=limit_in, count=0, prescaler=0, reached=0, reached_pulse=0, state=RUN. No step on the load edge.
- Step: in RUN with enable=1, prescaler increments; when prescaler==PRESCALE-1 it wraps to 0 and a step occurs this edge. With PRESCALE=1 every enabled edge is a step.
- On step: next = count+1 computed in WIDTH+1 bits (no wrap). If next >= limit → fire, else count<=next.
- Fire: reached<=1, reached_pulse<=1 (registered; high the cycle after the firing edge only).
  - mode=0: count<=limit, state<=DONE.
  - mode=1: count<=0, stay RUN; period = limit*PRESCALE enabled ticks.
- limit=0: fires on first step. One-shot: count stays 0. Periodic: fires every step.
- limit=2^WIDTH-1: count reaches max, no overflow or wrap.
- enable=0: prescaler, count, state frozen; reached_pulse still deasserts next cycle.
- DONE: count/state hold until load or reset; enable and mode ignored.
- mode is sampled at each fire; a change mid-run takes effect at the next fire.
- clear_flag: reached<=0 next edge. Does not restart the count. Fire and clear_flag on the same edge: set wins (reached=1).
- reached_pulse is 0 on every edge without a fire.

Test Plan:
- Default: reset 1 cycle, enable=1, mode=0, PRESCALE=1 -> reached and reached_pulse rise after 10th edge; pulse width 1 cycle; count=10 held; busy=0.
- Periodic prescaled: PRESCALE=4, load limit=3, mode=1 -> reached_pulse every 12 cycles; count sequence 0,1,2,0; reached stays 1.
- Enable gating: mode=0, drop enable for 5 cycles at count=4 -> count holds 4; fire delayed by exactly 5 cycles (15th edge).
- Load mid-run and limit 0: load limit=0 at count=6 -> count=0, reached=0; fire on next enabled step; count stays 0.
- Clear vs fire: assert clear_flag on the firing edge -> reached=1; clear_flag one edge later -> reached=0, count unchanged.
- Reset mid-run and max limit: WIDTH=4, load limit=15 -> fires at count=15 with no wrap; reset at count=7 in another run -> all outputs at reset values next edge.
